key_debounce_irq: RTL and testbench

Parametrised multi-channel debouncer for board push-buttons and switches, the next generation of the fixed two-key debouncer used in the DE10-Nano system tops. Each channel has:
- a synchroniser;
- per-channel polarity normalisation;
- a stable-time filter;
- press/release/long-press event pulses.

Events feed maskable, sticky pending bits that are ORed into one interrupt line, for the HPS f2h IRQ vector or a SoC GPIO/IRQ input.

---
 rtl/key_debounce_irq_pkg.sv | 19 +
 rtl/key_debounce_chan.sv | 116 +++++++++++
 rtl/key_debounce_irq.sv | 55 +++++
 tb/tb_key_debounce_irq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_irq_pkg.sv
// Shared types and default parameters for the key debouncer and its channels.
package key_debounce_irq_pkg;

    // Default configuration of a board build (50 MHz clock).
    localparam int DEF_WIDTH         = 2;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_TIMEOUT       = 50000;
    localparam int DEF_TIMEOUT_WIDTH = 16;
    localparam int DEF_LONG_CYCLES   = 50000000;
    localparam int DEF_LONG_WIDTH    = 26;

    // One-cycle events raised by a channel.
    typedef struct packed {
        logic press;
        logic rel;
        logic long_press;
    } key_evt_t;

endpackage

// File: rtl/key_debounce_chan.sv
// One debounced key: synchroniser, polarity fix, stable-time filter,
// press/release/long-press pulses and a sticky pending bit.
module key_debounce_chan
    import key_debounce_irq_pkg::*;
#(
    parameter logic POLARITY      = 1'b1,
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int   TIMEOUT       = DEF_TIMEOUT,
    parameter int   TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH,
    parameter int   LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int   LONG_WIDTH    = DEF_LONG_WIDTH
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     raw_i,
    input  logic     irq_clr_i,
    output logic     level_o,
    output key_evt_t evt_o,
    output logic     pending_o
);

    // Counters stop one short of the limit so the widths only need to hold
    // TIMEOUT-1 and LONG_CYCLES-1; a done flag stands in for saturation.
    localparam logic [TIMEOUT_WIDTH-1:0] FILT_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);
    localparam logic [LONG_WIDTH-1:0]    HOLD_LAST = LONG_WIDTH'(LONG_CYCLES - 1);

    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic [TIMEOUT_WIDTH-1:0] filt_cnt_q, filt_cnt_d;
    logic                     level_q, level_d;
    logic [LONG_WIDTH-1:0]    hold_cnt_q, hold_cnt_d;
    logic                     hold_done_q, hold_done_d;
    logic                     pending_q, pending_d;
    key_evt_t                 evt_q, evt_d;
    logic                     press_d, rel_d, long_d;
    logic                     act;

    // Shift the raw input through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    assign act = sync_q[SYNC_STAGES-1] ^ POLARITY;

    // Accept a new level only after it has differed for TIMEOUT samples in a row.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        filt_cnt_d = '0;
        level_d    = level_q;
        press_d    = 1'b0;
        rel_d      = 1'b0;
        if (act != level_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                level_d = act;
                press_d = act;
                rel_d   = ~act;
            end else begin
                filt_cnt_d = filt_cnt_q + TIMEOUT_WIDTH'(1);
            end
        end
    end

    // Time how long the key has been held; fire long-press once per press.
    always_comb begin
        hold_cnt_d  = '0;
        hold_done_d = 1'b0;
        long_d      = 1'b0;
        if (level_q) begin
            hold_cnt_d  = hold_cnt_q;
            hold_done_d = hold_done_q;
            if (!hold_done_q) begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_done_d = 1'b1;
                    long_d      = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + LONG_WIDTH'(1);
                end
            end
        end
    end

    // Sticky pending flag: a coinciding set beats the clear.
    always_comb begin
        pending_d = (pending_q & ~irq_clr_i) | evt_q.press | evt_q.long_press;
    end

    assign evt_d = '{press: press_d, rel: rel_d, long_press: long_d};

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the synchroniser resets to the idle raw level, not zero, so
            // leaving reset does not look like a key change.
            sync_q      <= {SYNC_STAGES{POLARITY}};
            filt_cnt_q  <= '0;
            level_q     <= 1'b0;
            hold_cnt_q  <= '0;
            hold_done_q <= 1'b0;
            pending_q   <= 1'b0;
            evt_q       <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            sync_q      <= sync_d;
            filt_cnt_q  <= filt_cnt_d;
            level_q     <= level_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_done_q <= hold_done_d;
            pending_q   <= pending_d;
            evt_q       <= evt_d;
        end
    end

    assign level_o   = level_q;
    assign evt_o     = evt_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/key_debounce_irq.sv
// Multi-channel key debouncer with a maskable, sticky interrupt line.
module key_debounce_irq
    import key_debounce_irq_pkg::*;
#(
    parameter int               WIDTH         = DEF_WIDTH,
    parameter logic [WIDTH-1:0] POLARITY_MASK = {WIDTH{1'b1}},
    parameter int               SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int               TIMEOUT       = DEF_TIMEOUT,
    parameter int               TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH,
    parameter int               LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int               LONG_WIDTH    = DEF_LONG_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] press_o,
    output logic [WIDTH-1:0] release_o,
    output logic [WIDTH-1:0] long_o,
    input  logic [WIDTH-1:0] irq_mask_i,
    input  logic [WIDTH-1:0] irq_clr_i,
    output logic [WIDTH-1:0] pending_o,
    output logic             irq_o
);

    key_evt_t evt [WIDTH];

    // One independent debouncer per key.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        key_debounce_chan #(
            .POLARITY      (POLARITY_MASK[i]),
            .SYNC_STAGES   (SYNC_STAGES),
            .TIMEOUT       (TIMEOUT),
            .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
            .LONG_CYCLES   (LONG_CYCLES),
            .LONG_WIDTH    (LONG_WIDTH)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .raw_i     (data_in[i]),
            .irq_clr_i (irq_clr_i[i]),
            .level_o   (data_out[i]),
            .evt_o     (evt[i]),
            .pending_o (pending_o[i])
        );

        assign press_o[i]   = evt[i].press;
        assign release_o[i] = evt[i].rel;
        assign long_o[i]    = evt[i].long_press;
    end

    // Mask is applied combinationally so changes show up immediately.
    assign irq_o = |(pending_o & irq_mask_i);

endmodule

// File: tb/tb_key_debounce_irq.sv
// Self-checking bench for key_debounce_irq: fixed vector table, hand-written
// corner sequences and random stimulus against a sliding-window model.
module tb_key_debounce_irq;

    localparam int         WIDTH   = 2;
    localparam logic [1:0] POL     = 2'b11;
    localparam int         SYNC    = 2;
    localparam int         TIMEOUT = 4;
    localparam int         LONG    = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] data_in = 2'b11;
    logic [1:0] irq_mask_i = 2'b00;
    logic [1:0] irq_clr_i = 2'b00;
    logic [1:0] data_out, press_o, release_o, long_o, pending_o;
    logic       irq_o;

    int checks = 0;
    int errors = 0;

    key_debounce_irq #(
        .WIDTH(WIDTH), .POLARITY_MASK(POL), .SYNC_STAGES(SYNC),
        .TIMEOUT(TIMEOUT), .TIMEOUT_WIDTH(2), .LONG_CYCLES(LONG), .LONG_WIDTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_out(data_out),
        .press_o(press_o), .release_o(release_o), .long_o(long_o),
        .irq_mask_i(irq_mask_i), .irq_clr_i(irq_clr_i),
        .pending_o(pending_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Raw samples go through a SYNC-deep delay line; a level is accepted once
    // the last TIMEOUT delayed samples all agree and differ from the output.
    bit         m_line [WIDTH][$];
    bit         m_win  [WIDTH][$];
    logic [1:0] m_dout, m_press, m_rel, m_long, m_pend;
    int         m_edge;
    int         m_press_edge [WIDTH];

    function automatic void m_init();
        logic [1:0] pol_v = POL;
        for (int i = 0; i < WIDTH; i++) begin
            m_line[i].delete();
            m_win[i].delete();
            for (int k = 0; k < SYNC; k++) m_line[i].push_back(pol_v[i]);
            m_press_edge[i] = -100000;
        end
        m_dout = '0; m_press = '0; m_rel = '0; m_long = '0; m_pend = '0;
        m_edge = 0;
    endfunction

    function automatic void m_step();
        logic [1:0] pol_v     = POL;
        logic [1:0] old_dout  = m_dout;
        logic [1:0] old_press = m_press;
        logic [1:0] old_long  = m_long;
        m_edge++;
        m_pend  = (m_pend & ~irq_clr_i) | old_press | old_long;
        m_press = '0; m_rel = '0; m_long = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bit s;
            bit same;
            s = m_line[i].pop_front() ^ pol_v[i];
            m_line[i].push_back(data_in[i]);
            if (old_dout[i] && m_edge == m_press_edge[i] + LONG) m_long[i] = 1'b1;
            m_win[i].push_back(s);
            if (m_win[i].size() > TIMEOUT) void'(m_win[i].pop_front());
            same = (m_win[i].size() == TIMEOUT);
            for (int k = 0; k < m_win[i].size(); k++)
                if (m_win[i][k] != s) same = 1'b0;
            if (same && s != old_dout[i]) begin
                m_dout[i] = s;
                if (s) begin
                    m_press[i] = 1'b1;
                    m_press_edge[i] = m_edge;
                end else begin
                    m_rel[i] = 1'b1;
                end
            end
        end
    endfunction

    initial m_init();

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_init();
        else          m_step();
    end

    task automatic cmp_model();
        check("model data_out",  32'(data_out),  32'(m_dout));
        check("model press_o",   32'(press_o),   32'(m_press));
        check("model release_o", 32'(release_o), 32'(m_rel));
        check("model long_o",    32'(long_o),    32'(m_long));
        check("model pending_o", 32'(pending_o), 32'(m_pend));
        check("model irq_o",     32'(irq_o),     32'(|(m_pend & irq_mask_i)));
    endtask

    // Drive one cycle of inputs at the falling edge, compare at the next one.
    task automatic step(input logic [1:0] din, input logic [1:0] mask, input logic [1:0] clr);
        data_in = din; irq_mask_i = mask; irq_clr_i = clr;
        @(posedge clk);
        @(negedge clk);
        cmp_model();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] din, mask, clr;
        logic [1:0] e_dout, e_press, e_rel, e_pend;
        logic       e_irq;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int pulses;
        int p_edge, p_cnt, p1_cnt, l_edge, l_cnt, r_edge;

        // Clean press on ch0, mask/clear, then release (one row per edge).
        for (int k = 1; k <= 5; k++) vecs.push_back('{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0});
        vecs.push_back('{2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1});
        vecs.push_back('{2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0});
        vecs.push_back('{2'b11, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0});
        for (int k = 10; k <= 13; k++) vecs.push_back('{2'b11, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0});
        vecs.push_back('{2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0});
        vecs.push_back('{2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0});

        // Reset with keys idle.
        repeat (3) @(negedge clk);
        check("in reset data_out", 32'(data_out), 32'd0);
        check("in reset pending",  32'(pending_o), 32'd0);
        #2 reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            step(2'b11, 2'b11, 2'b00);
            if ((press_o | release_o | long_o) != 2'b00) pulses++;
        end
        check("idle pulses", 32'(pulses), 32'd0);
        check("idle irq", 32'(irq_o), 32'd0);

        // Table.
        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].din, vecs[k].mask, vecs[k].clr);
            check($sformatf("vec%0d data_out", k + 1), 32'(data_out), 32'(vecs[k].e_dout));
            check($sformatf("vec%0d press", k + 1),    32'(press_o),  32'(vecs[k].e_press));
            check($sformatf("vec%0d release", k + 1),  32'(release_o), 32'(vecs[k].e_rel));
            check($sformatf("vec%0d pending", k + 1),  32'(pending_o), 32'(vecs[k].e_pend));
            check($sformatf("vec%0d irq", k + 1),      32'(irq_o),    32'(vecs[k].e_irq));
        end

        // Bounce: low 3, high 1, low -> press when 4 filtered lows line up.
        p_edge = -1; p_cnt = 0; p1_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            step((k == 4) ? 2'b11 : 2'b10, 2'b01, 2'b00);
            if (press_o[0]) begin p_cnt++; if (p_edge < 0) p_edge = k; end
            if (press_o[1]) p1_cnt++;
        end
        check("bounce press edge", 32'(p_edge), 32'd10);
        check("bounce press count", 32'(p_cnt), 32'd1);
        check("bounce ch1 silent", 32'(p1_cnt), 32'd0);
        repeat (10) step(2'b11, 2'b01, 2'b00);
        step(2'b11, 2'b01, 2'b01);
        repeat (4) step(2'b11, 2'b01, 2'b00);

        // Long press: hold well past the long-press point.
        p_edge = -1; l_edge = -1; l_cnt = 0;
        for (int k = 1; k <= 26; k++) begin
            step(2'b10, 2'b01, 2'b00);
            if (press_o[0] && p_edge < 0) p_edge = k;
            if (long_o[0]) begin l_cnt++; if (l_edge < 0) l_edge = k; end
        end
        check("long count", 32'(l_cnt), 32'd1);
        check("long delay", 32'(l_edge - p_edge), 32'(LONG));
        step(2'b10, 2'b01, 2'b01);
        r_edge = -1;
        for (int k = 1; k <= 8; k++) begin
            step(2'b11, 2'b01, 2'b00);
            if (release_o[0] && r_edge < 0) begin
                r_edge = k;
                check("release data_out", 32'(data_out[0]), 32'd0);
            end
        end
        check("release edge", 32'(r_edge), 32'd6);
        check("release no pending", 32'(pending_o), 32'd0);

        // Clear coinciding with press on ch1, then a lone clear.
        for (int k = 1; k <= 6; k++) step(2'b01, 2'b11, 2'b00);
        check("ch1 press", 32'(press_o), 32'h2);
        step(2'b01, 2'b11, 2'b10);
        check("set beats clear", 32'(pending_o[1]), 32'd1);
        step(2'b01, 2'b11, 2'b00);
        step(2'b01, 2'b11, 2'b10);
        check("lone clear", 32'(pending_o), 32'd0);
        repeat (8) step(2'b11, 2'b11, 2'b00);

        // Reset in the middle of a filter count.
        for (int k = 1; k <= 4; k++) step(2'b10, 2'b01, 2'b00);
        reset_n = 1'b0;
        #1;
        check("mid reset data_out", 32'(data_out), 32'd0);
        check("mid reset pulses", 32'(press_o | release_o | long_o), 32'd0);
        check("mid reset pending", 32'(pending_o), 32'd0);
        check("mid reset irq", 32'(irq_o), 32'd0);
        #1 reset_n = 1'b1;
        p_edge = -1;
        for (int k = 1; k <= 10; k++) begin
            step(2'b10, 2'b01, 2'b00);
            if (press_o[0] && p_edge < 0) p_edge = k;
        end
        check("post reset press edge", 32'(p_edge), 32'(SYNC + TIMEOUT));
        repeat (20) step(2'b11, 2'b01, 2'b11);

        // Random keys, masks and clears against the model.
        for (int seg = 0; seg < 80; seg++) begin
            logic [1:0] din;
            int hold;
            din  = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 22);
            for (int k = 0; k < hold; k++) begin
                logic [1:0] clr;
                clr[0] = ($urandom_range(0, 7) == 0);
                clr[1] = ($urandom_range(0, 7) == 0);
                step(din, 2'($urandom_range(0, 3)), clr);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
